// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two requesters share one bit-serial adder under round-robin arbitration
module serial_add_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             MasterClock,
    input  logic             resetl,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             owner
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] aSh, bSh, rSh;
    logic [CW-1:0]    cnt;
    logic             carry, lastOwner;
    logic             h1Q, h1Co, h2Q, h2Co;
    logic             grant, grantValid;

    // One serial adder slice: two half-adder cells with their carries ORed
    always_comb begin
        h1Q  = aSh[0] ^ bSh[0];
        h1Co = aSh[0] & bSh[0];
        h2Q  = h1Q ^ carry;
        h2Co = h1Q & carry;
    end

    // A lone request wins outright; a tie goes to whoever was not served last
    always_comb begin
        grantValid = req0 | req1;
        grant      = (req0 & req1) ? ~lastOwner : req1;
    end

    // Arbitration and shift sequencing; every output is a register of this FSM
    always_ff @(posedge MasterClock or negedge resetl) begin
        if (!resetl) begin
            state     <= IDLE;
            sum       <= '0;
            cout      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            lastOwner <= 1'b1;
            aSh       <= '0;
            bSh       <= '0;
            rSh       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        owner <= grant;
                        aSh   <= grant ? a1 : a0;
                        bSh   <= grant ? b1 : b0;
                        carry <= grant ? cin1 : cin0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    rSh   <= {h2Q, rSh[WIDTH-1:1]};
                    aSh   <= aSh >> 1;
                    bSh   <= bSh >> 1;
                    carry <= h1Co | h2Co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    sum       <= rSh;
                    cout      <= carry;
                    lastOwner <= owner;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed vectors for the shared serial adder
module tb_serial_add_arbiter;
    localparam int WIDTH = 16;

    logic             MasterClock = 1'b0;
    logic             resetl = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             ack0, ack1, cout, busy, owner;
    logic [WIDTH-1:0] sum;
    int               nCompared = 0, nMismatched = 0;
    int               cyc, nAck, nSeen;

    always #5 MasterClock = ~MasterClock;

    serial_add_arbiter #(.WIDTH(WIDTH)) dut (
        .MasterClock(MasterClock),
        .resetl(resetl),
        .req0(req0),
        .a0(a0),
        .b0(b0),
        .cin0(cin0),
        .req1(req1),
        .a1(a1),
        .b1(b1),
        .cin1(cin1),
        .ack0(ack0),
        .ack1(ack1),
        .sum(sum),
        .cout(cout),
        .busy(busy),
        .owner(owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts negedges from the current point; returns the index of the first one with the ack high
    task automatic waitAck(input bit who, output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge MasterClock);
            if ((who ? ack1 : ack0) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #1 resetl = 1'b0;
        #3;
        check("rst busy", busy, 0);
        check("rst sum", sum, 0);
        check("rst cout", cout, 0);
        check("rst ack0", ack0, 0);
        check("rst ack1", ack1, 0);
        check("rst owner", owner, 0);
        @(posedge MasterClock); #3 resetl = 1'b1;

        // 1: plain add on requester 0
        @(posedge MasterClock); #1;
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b0;
        @(posedge MasterClock);
        waitAck(1'b0, cyc);
        check("t1 ack0 cycle", cyc, 17);
        check("t1 ack1 quiet", ack1, 0);
        @(posedge MasterClock); #1 req0 = 1'b0;
        @(negedge MasterClock);
        check("t1 sum", sum, 16'h5555);
        check("t1 cout", cout, 0);
        check("t1 ack0 one cycle", ack0, 0);
        check("t1 busy idle", busy, 0);

        // 2: full ripple on requester 1
        req1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0000; cin1 = 1'b1;
        @(posedge MasterClock);
        waitAck(1'b1, cyc);
        check("t2 ack1 cycle", cyc, 17);
        check("t2 owner", owner, 1);
        @(posedge MasterClock); #1 req1 = 1'b0;
        @(negedge MasterClock);
        check("t2 sum", sum, 16'h0000);
        check("t2 cout", cout, 1);

        // 6: request and operands change mid-shift
        req1 = 1'b1; a1 = 16'h00F0; b1 = 16'h0F0F; cin1 = 1'b0;
        @(posedge MasterClock);
        repeat (2) @(posedge MasterClock);
        #1 req1 = 1'b0; a1 = 16'hFFFF; b1 = 16'hFFFF; cin1 = 1'b1;
        waitAck(1'b1, cyc);
        check("t6 ack1 cycle", (cyc < 0) ? cyc : cyc + 2, 17);
        @(posedge MasterClock); #1;
        @(negedge MasterClock);
        check("t6 sum", sum, 16'h0FFF);
        check("t6 cout", cout, 0);

        // 5: reset in shift cycle 5 aborts the op
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001; cin0 = 1'b0;
        @(posedge MasterClock);
        @(negedge MasterClock);
        check("t5 busy shift", busy, 1);
        repeat (4) @(posedge MasterClock);
        #1 resetl = 1'b0; req0 = 1'b0;
        #1;
        check("t5 busy rst", busy, 0);
        check("t5 sum rst", sum, 0);
        check("t5 cout rst", cout, 0);
        check("t5 ack0 rst", ack0, 0);
        check("t5 ack1 rst", ack1, 0);
        #10 resetl = 1'b1;
        nSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge MasterClock);
            if (ack0 | ack1) nSeen++;
        end
        check("t5 no ack", nSeen, 0);
        check("t5 busy after", busy, 0);

        // 3: simultaneous requests right after reset
        #2 resetl = 1'b0;
        @(posedge MasterClock); #3 resetl = 1'b1;
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; cin0 = 1'b0;
        req1 = 1'b1; a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b1;
        @(posedge MasterClock);
        waitAck(1'b0, cyc);
        check("t3 ack0 cycle", cyc, 17);
        check("t3 ack1 quiet", ack1, 0);
        @(posedge MasterClock); #1 req0 = 1'b0;
        waitAck(1'b1, cyc);
        check("t3 ack1 cycle", (cyc < 0) ? cyc : cyc + 17, 35);
        check("t3 owner", owner, 1);
        check("t3 sum op0", sum, 16'h0003);
        @(posedge MasterClock); #1 req1 = 1'b0;
        @(negedge MasterClock);
        check("t3 sum op1", sum, 16'h0001);
        check("t3 cout op1", cout, 1);

        // 4: both held for four ops alternate ownership
        #2 resetl = 1'b0;
        @(posedge MasterClock); #3 resetl = 1'b1;
        req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0;
        req1 = 1'b1; a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1'b0;
        @(posedge MasterClock);
        nAck = 0;
        for (int k = 1; k <= 100 && nAck < 4; k++) begin
            @(negedge MasterClock);
            if (ack0 | ack1) begin
                check($sformatf("t4 ack%0d which", nAck), ack1, nAck % 2);
                check($sformatf("t4 ack%0d both", nAck), ack0 & ack1, 0);
                check($sformatf("t4 ack%0d owner", nAck), owner, nAck % 2);
                check($sformatf("t4 ack%0d cycle", nAck), k, 17 + 18 * nAck);
                if (nAck > 0) check($sformatf("t4 ack%0d sum", nAck), sum, (nAck % 2) ? 16'h0100 : 16'h8000);
                nAck++;
            end
        end
        check("t4 ack count", nAck, 4);
        @(posedge MasterClock); #1 req0 = 1'b0; req1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
